// File: rtl/core_supervisor_pkg.sv
// Shared status encoding and FSM state type for the core supervisor.
// The per-core status codes are decoded on the core side from these constants.
package core_supervisor_pkg;

   localparam logic [1:0] STAT_IDLE  = 2'b00;
   localparam logic [1:0] STAT_START = 2'b01;
   localparam logic [1:0] STAT_RUN   = 2'b10;
   localparam logic [1:0] STAT_HALT  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_START = 2'b01,
      S_RUN   = 2'b10,
      S_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/core_supervisor_done_tracker.sv
// Sticky per-core completion flags for one job; all_done also counts bits
// that arrive in the current cycle so completion needs no extra cycle.
module done_tracker #(
   parameter int NUM_CORES = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [NUM_CORES-1:0] end_process,
   output logic                 all_done
);

   logic [NUM_CORES-1:0] flags_q, flags_d, live;

   assign live     = end_process & {NUM_CORES{enable}};
   assign all_done = &(flags_q | live);

   always_comb begin
      flags_d = flags_q;
      if (clear) begin
         flags_d = '0;
      end else begin
         flags_d = flags_q | live;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

endmodule

// File: rtl/core_supervisor.sv
// Supervises NUM_CORES matmul cores: IDLE -> START -> RUN -> DONE job sequencing.
// Optional RUN watchdog enabled by defining CORE_SUPERVISOR_WATCHDOG_EN.
module core_supervisor
   import core_supervisor_pkg::*;
#(
   parameter int NUM_CORES      = 4,
   parameter int START_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [NUM_CORES-1:0]   end_process,
   output logic [2*NUM_CORES-1:0] status,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout,
   output logic [15:0]            cycle_count
);

   localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

   if (START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("core_supervisor: START_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   state_t         state_q, state_d;
   logic [SCW-1:0] start_cnt_q, start_cnt_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           enter_start;
   logic           all_done;
   logic [1:0]     code;

`ifdef CORE_SUPERVISOR_WATCHDOG_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic timeout_q, timeout_d;
`endif

   done_tracker #(.NUM_CORES(NUM_CORES)) u_done_tracker (
      .clock       (clock),
      .reset_n     (reset_n),
      .clear       (enter_start),
      .enable      (state_q == S_RUN),
      .end_process (end_process),
      .all_done    (all_done)
   );

   always_comb begin
      state_d     = state_q;
      start_cnt_d = start_cnt_q;
      cnt_d       = cnt_q;
      enter_start = 1'b0;
`ifdef CORE_SUPERVISOR_WATCHDOG_EN
      timeout_d   = timeout_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_START;
               enter_start = 1'b1;
            end
         end
         S_START: begin
            if (start_cnt_q == START_LAST) begin
               state_d = S_RUN;
            end else begin
               start_cnt_d = start_cnt_q + SCW'(1);
            end
         end
         S_RUN: begin
            if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
            // Completion wins over a watchdog expiry in the same cycle.
            if (all_done) begin
               state_d = S_DONE;
            end
`ifdef CORE_SUPERVISOR_WATCHDOG_EN
            else if (cnt_q == TO_LAST) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_start) begin
         start_cnt_d = '0;
         cnt_d       = '0;
`ifdef CORE_SUPERVISOR_WATCHDOG_EN
         timeout_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         start_cnt_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         start_cnt_q <= start_cnt_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef CORE_SUPERVISOR_WATCHDOG_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      code = STAT_IDLE;
      case (state_q)
         S_IDLE:  code = STAT_IDLE;
         S_START: code = STAT_START;
         S_RUN:   code = STAT_RUN;
         S_DONE:  code = STAT_HALT;
         default: code = STAT_IDLE;
      endcase
   end

   assign status      = {NUM_CORES{code}};
   assign busy        = (state_q == S_START) || (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign cycle_count = cnt_q;

endmodule
